// File: rtl/switch_cfg_ctrl_if.sv
// Consumer handshake bundle for switch_cfg_ctrl.
// cfg_valid/cfg_data: producer -> consumer; cfg_ready: consumer -> producer.
interface switch_cfg_ctrl_if;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [15:0] cfg_data;

    modport master (
        output cfg_valid,
        output cfg_data,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_data,
        output cfg_ready
    );
endinterface

// File: rtl/switch_cfg_ctrl.sv
// Switch debouncer/publisher: samples a synchronized 16-bit switch vector
// every SAMPLE_DIV clocks, accepts it after HOLD_SAMPLES equal samples and
// offers it to a consumer over a valid/ready handshake.
// Ports: clk, rst (async, active-high), sw_in (raw), sw_stable (published),
//        cfg (master: cfg_valid, cfg_data, cfg_ready), busy, chg_cnt.
// Optional: define SWITCH_CFG_CTRL_CHG_CNT_EN to build the update counter;
//           otherwise chg_cnt is tied to 0.
module switch_cfg_ctrl #(
    parameter int SAMPLE_DIV   = 1000,
    parameter int HOLD_SAMPLES = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [15:0]          sw_in,
    output logic [15:0]          sw_stable,
    switch_cfg_ctrl_if.master    cfg,
    output logic                 busy,
    output logic [7:0]           chg_cnt
);

    localparam logic [15:0] DIV_LAST  = 16'(SAMPLE_DIV - 1);
    localparam logic [7:0]  HOLD_LAST = 8'(HOLD_SAMPLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        PUBLISH
    } state_t;

    logic [15:0] sync1_q, sync1_d;
    logic [15:0] sync2_q, sync2_d;
    logic [15:0] div_q, div_d;
    logic        tick;
    state_t      state_q, state_d;
    logic [7:0]  hold_q, hold_d;
    logic [15:0] cand_q, cand_d;
    logic [15:0] stable_q, stable_d;
    logic        valid_q, valid_d;
    logic        busy_q, busy_d;

    assign tick = (div_q == DIV_LAST);

    always_comb begin
        sync1_d  = sw_in;
        sync2_d  = sync1_q;
        div_d    = tick ? 16'd0 : div_q + 16'd1;
        state_d  = state_q;
        hold_d   = hold_q;
        cand_d   = cand_q;
        stable_d = stable_q;
        unique case (state_q)
            IDLE: begin
                if (tick && (sync2_q != stable_q)) begin
                    cand_d  = sync2_q;
                    hold_d  = 8'd1;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (tick) begin
                    if (sync2_q == stable_q) begin
                        // Input fell back to the published value: glitch.
                        state_d = IDLE;
                    end else if (sync2_q == cand_q) begin
                        if (hold_q == HOLD_LAST) begin
                            state_d = PUBLISH;
                        end else begin
                            hold_d = hold_q + 8'd1;
                        end
                    end else begin
                        // A third value appeared: restart the hold window.
                        cand_d = sync2_q;
                        hold_d = 8'd1;
                    end
                end
            end
            PUBLISH: begin
                // Leaves on the handshake alone, independent of tick.
                if (valid_q && cfg.cfg_ready) begin
                    stable_d = cand_q;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Outputs are registered from the next state so they align with it.
        valid_d = (state_d == PUBLISH);
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            div_q    <= '0;
            state_q  <= IDLE;
            hold_q   <= '0;
            cand_q   <= '0;
            stable_q <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            div_q    <= div_d;
            state_q  <= state_d;
            hold_q   <= hold_d;
            cand_q   <= cand_d;
            stable_q <= stable_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
        end
    end

`ifdef SWITCH_CFG_CTRL_CHG_CNT_EN
    logic [7:0] chg_q, chg_d;
    logic       hs;

    always_comb begin
        hs    = (state_q == PUBLISH) && valid_q && cfg.cfg_ready;
        chg_d = hs ? chg_q + 8'd1 : chg_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chg_q <= '0;
        end else begin
            chg_q <= chg_d;
        end
    end

    assign chg_cnt = chg_q;
`else
    assign chg_cnt = 8'd0;
`endif

    assign sw_stable     = stable_q;
    assign cfg.cfg_valid = valid_q;
    assign cfg.cfg_data  = cand_q;
    assign busy          = busy_q;

endmodule
